// File: rtl/rv32_alu_mc.sv
// rv32_alu_mc: XLEN-wide execute unit; one-cycle ALU ops plus iterative
// shift-add multiply and restoring divide behind valid/ready handshakes.
module rv32_alu_mc #(
  parameter int XLEN      = 32,
  parameter bit EN_MULDIV = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] rsa_i,
  input  logic [XLEN-1:0] rsb_imm_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            illegal_o
);
  localparam int SHW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} st_t;
  st_t             r_st;
  logic [SHW-1:0]  r_cnt;
  logic [XLEN-1:0] r_hi, r_lo, r_a, r_res;
  logic            r_neg, r_div, r_hisel, r_ill;
  logic            w_acc, w_lt, w_ltu, w_eq, w_ill, w_m, w_isdiv, w_sdiv, w_isrem;
  logic            w_dz, w_ovf, w_fast, w_sa, w_sb, w_an, w_bn, w_qb;
  logic [SHW-1:0]  w_sh;
  logic [XLEN-1:0] w_alu, w_fres, w_ua, w_ub, w_min;
  logic [XLEN:0]   w_sum, w_rsh, w_dif;
  assign ready_o   = (r_st == IDLE) || (r_st == DONE && ready_i);
  assign valid_o   = r_st == DONE;
  assign result_o  = r_res;
  assign illegal_o = r_ill;
  assign w_acc     = valid_i && ready_o && !flush_i;
  assign w_sh      = rsb_imm_i[SHW-1:0];
  assign w_lt      = $signed(rsa_i) < $signed(rsb_imm_i);
  assign w_ltu     = rsa_i < rsb_imm_i;
  assign w_eq      = rsa_i == rsb_imm_i;
  assign w_min     = {1'b1, {(XLEN-1){1'b0}}};
  always_comb begin
    w_alu = '0;
    case (op_i)
      5'd0:  w_alu = rsa_i + rsb_imm_i;
      5'd1:  w_alu = rsa_i - rsb_imm_i;
      5'd2:  w_alu = rsa_i & rsb_imm_i;
      5'd3:  w_alu = rsa_i | rsb_imm_i;
      5'd4:  w_alu = rsa_i ^ rsb_imm_i;
      5'd5:  w_alu = rsa_i << w_sh;
      5'd6:  w_alu = rsa_i >> w_sh;
      5'd7:  w_alu = $unsigned($signed(rsa_i) >>> w_sh);
      5'd8:  w_alu = {{(XLEN-1){1'b0}}, w_lt};
      5'd9:  w_alu = {{(XLEN-1){1'b0}}, w_ltu};
      5'd10: w_alu = {XLEN{w_eq}};
      5'd11: w_alu = {XLEN{!w_eq}};
      5'd12: w_alu = {XLEN{w_lt}};
      5'd13: w_alu = {XLEN{!w_lt}};
      5'd14: w_alu = {XLEN{w_ltu}};
      5'd15: w_alu = {XLEN{!w_ltu}};
      5'd16: w_alu = rsb_imm_i;
      default: w_alu = '0;
    endcase
  end
  // Divide-by-zero and signed overflow resolve at accept, like plain ALU ops
  assign w_m    = EN_MULDIV && op_i >= 5'd17 && op_i <= 5'd24;
  assign w_ill  = op_i > 5'd24 || (op_i >= 5'd17 && !EN_MULDIV);
  assign w_isdiv = w_m && op_i >= 5'd21;
  assign w_sdiv = op_i == 5'd21 || op_i == 5'd23;
  assign w_isrem = op_i == 5'd23 || op_i == 5'd24;
  assign w_dz   = w_isdiv && rsb_imm_i == '0;
  assign w_ovf  = w_isdiv && w_sdiv && rsa_i == w_min && rsb_imm_i == '1;
  assign w_fast = !w_m || w_dz || w_ovf;
  assign w_fres = w_ill ? '0 :
                  w_dz  ? (w_isrem ? rsa_i : '1) :
                  w_ovf ? (w_isrem ? '0 : rsa_i) : w_alu;
  assign w_sa   = op_i == 5'd18 || op_i == 5'd19 || w_sdiv;
  assign w_sb   = op_i == 5'd18 || w_sdiv;
  assign w_an   = w_sa && rsa_i[XLEN-1];
  assign w_bn   = w_sb && rsb_imm_i[XLEN-1];
  assign w_ua   = w_an ? -rsa_i : rsa_i;
  assign w_ub   = w_bn ? -rsb_imm_i : rsb_imm_i;
  // r_lo holds the multiplier (shifted out) or dividend (quotient shifted in)
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_rsh  = {r_hi, r_lo[XLEN-1]};
  assign w_dif  = w_rsh - {1'b0, r_a};
  assign w_qb   = !w_dif[XLEN];
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_st  <= IDLE;
      r_cnt <= '0;
      r_res <= '0;
      r_ill <= 1'b0;
    end else if (flush_i) begin
      r_st  <= IDLE;
      r_cnt <= '0;
    end else begin
      case (r_st)
        ITER: begin
          r_hi  <= r_div ? (w_qb ? w_dif[XLEN-1:0] : w_rsh[XLEN-1:0]) : w_sum[XLEN:1];
          r_lo  <= r_div ? {r_lo[XLEN-2:0], w_qb} : {w_sum[0], r_lo[XLEN-1:1]};
          r_cnt <= r_cnt + SHW'(1);
          if (r_cnt == SHW'(XLEN-1)) r_st <= FIX;
        end
        FIX: begin
          // Two phases: sign-correct in place, then select into the result
          if (!r_cnt[0]) begin
            if (r_neg) {r_hi, r_lo} <= r_div ? {-r_hi, -r_lo} : -{r_hi, r_lo};
            r_cnt <= SHW'(1);
          end else begin
            r_res <= r_hisel ? r_hi : r_lo;
            r_ill <= 1'b0;
            r_cnt <= '0;
            r_st  <= DONE;
          end
        end
        default: begin
          if (w_acc) begin
            if (w_fast) begin
              r_res <= w_fres;
              r_ill <= w_ill;
              r_st  <= DONE;
            end else begin
              r_hi    <= '0;
              r_lo    <= w_ua;
              r_a     <= w_ub;
              r_neg   <= (op_i == 5'd23) ? w_an : (w_an ^ w_bn);
              r_div   <= w_isdiv;
              r_hisel <= op_i == 5'd18 || op_i == 5'd19 || op_i == 5'd20 || w_isrem;
              r_cnt   <= '0;
              r_st    <= ITER;
            end
          end else if (r_st == DONE && ready_i) begin
            r_st <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rv32_alu_mc.sv
// tb_rv32_alu_mc: directed vector tables plus handshake, flush and reset
// sequences for the multi-cycle execute unit.
module tb_rv32_alu_mc;
  logic        clk_i = 1'b0;
  logic        rst_n_i, valid_i, flush_i, ready_i;
  logic [4:0]  op_i;
  logic [31:0] rsa_i, rsb_imm_i;
  logic        ready_o, valid_o, illegal_o;
  logic [31:0] result_o;
  logic        ready2, valid2, illegal2;
  logic [31:0] result2;
  int          n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        il;
  } vec_t;
  vec_t sv[22];
  vec_t mv[13];
  always #5 clk_i = ~clk_i;
  rv32_alu_mc #(.XLEN(32), .EN_MULDIV(1'b1)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .rsa_i(rsa_i), .rsb_imm_i(rsb_imm_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .illegal_o(illegal_o));
  rv32_alu_mc #(.XLEN(32), .EN_MULDIV(1'b0)) dut_nm (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready2),
    .op_i(op_i), .rsa_i(rsa_i), .rsb_imm_i(rsb_imm_i), .flush_i(flush_i),
    .valid_o(valid2), .ready_i(ready_i), .result_o(result2), .illegal_o(illegal2));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic drive(input vec_t v);
    valid_i = 1'b1;
    op_i = v.op;
    rsa_i = v.a;
    rsb_imm_i = v.b;
  endtask
  initial begin
    int cnt, bad;
    sv[0]  = '{5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    sv[1]  = '{5'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0};
    sv[2]  = '{5'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
    sv[3]  = '{5'd3,  32'h00000F00, 32'h000000F0, 32'h00000FF0, 1'b0};
    sv[4]  = '{5'd4,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
    sv[5]  = '{5'd5,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0};
    sv[6]  = '{5'd6,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0};
    sv[7]  = '{5'd7,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0};
    sv[8]  = '{5'd8,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    sv[9]  = '{5'd9,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    sv[10] = '{5'd10, 32'h00000005, 32'h00000005, 32'hFFFFFFFF, 1'b0};
    sv[11] = '{5'd11, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
    sv[12] = '{5'd12, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    sv[13] = '{5'd13, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};
    sv[14] = '{5'd14, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};
    sv[15] = '{5'd15, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    sv[16] = '{5'd16, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 1'b0};
    sv[17] = '{5'd27, 32'h00000003, 32'h00000004, 32'h00000000, 1'b1};
    sv[18] = '{5'd22, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    sv[19] = '{5'd23, 32'h00000007, 32'h00000000, 32'h00000007, 1'b0};
    sv[20] = '{5'd21, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0};
    sv[21] = '{5'd23, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    mv[0]  = '{5'd18, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    mv[1]  = '{5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    mv[2]  = '{5'd20, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    mv[3]  = '{5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    mv[4]  = '{5'd17, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 1'b0};
    mv[5]  = '{5'd18, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0};
    mv[6]  = '{5'd21, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
    mv[7]  = '{5'd23, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    mv[8]  = '{5'd22, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0};
    mv[9]  = '{5'd24, 32'h00000064, 32'h00000007, 32'h00000002, 1'b0};
    mv[10] = '{5'd21, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    mv[11] = '{5'd23, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    mv[12] = '{5'd21, 32'h80000000, 32'h00000002, 32'hC0000000, 1'b0};
    rst_n_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    op_i = '0; rsa_i = '0; rsb_imm_i = '0;
    tick(); tick();
    rst_n_i = 1'b1;
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    chk("rst_result", result_o, 32'd0);
    chk("rst_illegal", {31'b0, illegal_o}, 32'd0);
    // Single-cycle table, one request per cycle
    drive(sv[0]);
    for (int i = 1; i <= 22; i++) begin
      tick();
      chk($sformatf("sc%0d_valid", i-1), {31'b0, valid_o}, 32'd1);
      chk($sformatf("sc%0d_result", i-1), result_o, sv[i-1].r);
      chk($sformatf("sc%0d_illegal", i-1), {31'b0, illegal_o}, {31'b0, sv[i-1].il});
      chk($sformatf("sc%0d_ready", i-1), {31'b0, ready_o}, 32'd1);
      if (i < 22) drive(sv[i]);
      else valid_i = 1'b0;
    end
    tick();
    chk("sc_idle", {31'b0, valid_o}, 32'd0);
    // Iterative table: latency 34, ready_o low while busy
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("mc%0d_acc_ready", i), {31'b0, ready_o}, 32'd1);
      drive(mv[i]);
      tick();
      valid_i = 1'b0;
      cnt = 0;
      bad = 0;
      while (!valid_o && cnt < 100) begin
        if (ready_o) bad++;
        tick();
        cnt++;
      end
      chk($sformatf("mc%0d_latency", i), cnt, 32'd34);
      chk($sformatf("mc%0d_busy_ready", i), bad, 32'd0);
      chk($sformatf("mc%0d_result", i), result_o, mv[i].r);
      chk($sformatf("mc%0d_illegal", i), {31'b0, illegal_o}, 32'd0);
    end
    tick();
    // Backpressure: result held, new request ignored, then taken on release
    ready_i = 1'b0;
    drive('{5'd0, 32'd3, 32'd4, 32'd7, 1'b0});
    tick();
    drive('{5'd0, 32'd100, 32'd1, 32'd101, 1'b0});
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_ready", i), {31'b0, ready_o}, 32'd0);
      chk($sformatf("bp%0d_valid", i), {31'b0, valid_o}, 32'd1);
      chk($sformatf("bp%0d_result", i), result_o, 32'd7);
      tick();
    end
    ready_i = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, ready_o}, 32'd1);
    tick();
    valid_i = 1'b0;
    chk("bp_next_valid", {31'b0, valid_o}, 32'd1);
    chk("bp_next_result", result_o, 32'd101);
    tick();
    // Flush at ITER count 10, with a request presented alongside the flush
    drive('{5'd22, 32'd1000, 32'd3, 32'd333, 1'b0});
    tick();
    valid_i = 1'b0;
    repeat (10) tick();
    flush_i = 1'b1;
    drive('{5'd0, 32'd1, 32'd1, 32'd2, 1'b0});
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("flush_valid", {31'b0, valid_o}, 32'd0);
    chk("flush_ready", {31'b0, ready_o}, 32'd1);
    chk("flush_result", result_o, 32'd101);
    bad = 0;
    repeat (40) begin
      tick();
      if (valid_o) bad++;
    end
    chk("flush_no_valid", bad, 32'd0);
    // Illegal op, then reset in the middle of a divide
    drive(sv[17]);
    tick();
    chk("ill_valid", {31'b0, valid_o}, 32'd1);
    chk("ill_flag", {31'b0, illegal_o}, 32'd1);
    chk("ill_result", result_o, 32'd0);
    drive('{5'd21, 32'd100, 32'd3, 32'd33, 1'b0});
    tick();
    valid_i = 1'b0;
    repeat (5) tick();
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    chk("rstmid_valid", {31'b0, valid_o}, 32'd0);
    chk("rstmid_illegal", {31'b0, illegal_o}, 32'd0);
    chk("rstmid_ready", {31'b0, ready_o}, 32'd1);
    drive('{5'd0, 32'd2, 32'd3, 32'd5, 1'b0});
    tick();
    valid_i = 1'b0;
    chk("post_rst_add_valid", {31'b0, valid_o}, 32'd1);
    chk("post_rst_add", result_o, 32'd5);
    ready_i = 1'b0;
    tick();
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    ready_i = 1'b1;
    chk("rstdone_valid", {31'b0, valid_o}, 32'd0);
    chk("rstdone_result", result_o, 32'd0);
    // Multiply on the unit built without M ops is illegal with latency 1
    drive('{5'd17, 32'd3, 32'd3, 32'd9, 1'b0});
    tick();
    valid_i = 1'b0;
    chk("nomd_valid", {31'b0, valid2}, 32'd1);
    chk("nomd_illegal", {31'b0, illegal2}, 32'd1);
    chk("nomd_result", result2, 32'd0);
    chk("md_busy", {31'b0, ready_o}, 32'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("final_flush_valid", {31'b0, valid_o}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
